// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS pipeline control blocks.
//   ctrlState_e : sequencing FSM states (RUN, IMISS, DMISS)
//   REG_ADDR_W  : register-address width
//   REG_ZERO    : the hardwired $zero register, never a real dependency
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2
  } ctrlState_e;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Combinational load-use detector between IF/ID and ID/EX.
// Ports:
//   idRs, idRt  : source fields of the instruction in IF/ID
//   idUsesRt    : IF/ID instruction actually reads rt
//   exMemRead   : ID/EX holds a load
//   exRt        : destination of that load
//   loadUse     : one bubble is needed before the IF/ID instruction may issue
module hazard_detect #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRt,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRt,
  output logic                  loadUse
);
  import mips_pkg::*;

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exRt == idRs);
  // rt only matters when the consumer really reads it (e.g. not the
  // destination of an I-type instruction).
  assign rtMatch = idUsesRt && (exRt == idRt);

  // A load into $zero produces nothing that can be consumed.
  assign loadUse = exMemRead && (exRt != REG_ADDR_W'(REG_ZERO)) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the five-stage MIPS core. Freezes or
// bubbles the pipeline on cache misses, load-use hazards and taken branches,
// and owns the single main-memory refill port (req/ack handshake).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   if_hit               : I-cache hit for the current fetch
//   dm_access, dm_hit    : MEM-stage access and its D-cache hit
//   id_rs, id_rt,
//   id_uses_rt           : IF/ID source operands
//   ex_mem_read, ex_rt   : ID/EX load and its destination
//   ex_branch_taken      : branch resolved taken in EX
//   mem_ack              : one-cycle refill-complete pulse
//   mem_req, mem_sel     : refill request and target (0 = I$, 1 = D$)
//   pc_we .. exmem_we    : pipeline register enables, flush and bubble
//   stall_cycles         : saturating count of cycles with pc_we = 0
//   state                : current FSM state
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_hit,
  input  logic                  dm_access,
  input  logic                  dm_hit,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_sel,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_we,
  output logic                  idex_bubble,
  output logic                  exmem_we,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [1:0]            state
);
  import mips_pkg::*;

  ctrlState_e stateQ;
  logic       dMiss;
  logic       iMiss;
  logic       loadUse;

  assign dMiss = dm_access && !dm_hit;
  assign iMiss = !if_hit;
  assign state = stateQ;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) uHazard (
    .idRs     (id_rs),
    .idRt     (id_rt),
    .idUsesRt (id_uses_rt),
    .exMemRead(ex_mem_read),
    .exRt     (ex_rt),
    .loadUse  (loadUse)
  );

  // Refill FSM. mem_req/mem_sel are registered alongside the state so they
  // always equal (state != RUN) / (state == DMISS). An I-refill that finds a
  // pending D-miss goes straight on to serve the data side; a branch in
  // IMISS never cancels the refill, the wrong-path line is simply filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= RUN;
      mem_req <= 1'b0;
      mem_sel <= 1'b0;
    end else begin
      case (stateQ)
        RUN: begin
          if (dMiss) begin
            stateQ  <= DMISS;
            mem_req <= 1'b1;
            mem_sel <= 1'b1;
          end else if (iMiss) begin
            stateQ  <= IMISS;
            mem_req <= 1'b1;
            mem_sel <= 1'b0;
          end
        end
        IMISS: begin
          if (mem_ack) begin
            if (dMiss) begin
              stateQ  <= DMISS;
              mem_req <= 1'b1;
              mem_sel <= 1'b1;
            end else begin
              stateQ  <= RUN;
              mem_req <= 1'b0;
              mem_sel <= 1'b0;
            end
          end
        end
        DMISS: begin
          if (mem_ack) begin
            stateQ  <= RUN;
            mem_req <= 1'b0;
            mem_sel <= 1'b0;
          end
        end
        default: begin
          stateQ  <= RUN;
          mem_req <= 1'b0;
          mem_sel <= 1'b0;
        end
      endcase
    end
  end

  // Priority mux for the pipeline-register controls. A data miss freezes
  // everything, including a branch redirect, since the instruction in MEM
  // cannot retire. A taken branch still redirects the PC during an I-miss.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    if (rst_n) begin
      if (dMiss || stateQ == DMISS) begin
        pc_we = 1'b0;
      end else if (ex_branch_taken) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
      end else if (iMiss || stateQ == IMISS || loadUse) begin
        // Front end holds, back end drains behind a bubble.
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
      end
    end
  end

  // Stall counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_we && stall_cycles != {CNT_W{1'b1}}) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It watches the fetch-stage cache hit, the data-cache hit, load-use dependencies between IF/ID and ID/EX, and taken branches in EX. From these it drives the write enables, flushes and bubble insertion of the pipeline registers. It also owns the single main-memory refill port, which it serves with a req/ack handshake for instruction and data misses.

## Interface
- `REG_ADDR_W`, default 5: register-address width.
- `CNT_W`, default 32: stall-counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous reset, active low.
- `if_hit` in 1: instruction cache hit for the current fetch.
- `dm_access` in 1: MEM stage performs a load or store this cycle.
- `dm_hit` in 1: data cache hit for that access.
- `id_rs` in REG_ADDR_W: rs field of the instruction in IF/ID.
- `id_rt` in REG_ADDR_W: rt field of the instruction in IF/ID.
- `id_uses_rt` in 1: IF/ID instruction reads rt as a source.
- `ex_mem_read` in 1: ID/EX MemRead.
- `ex_rt` in REG_ADDR_W: ID/EX rt, the load destination.
- `ex_branch_taken` in 1: branch resolved taken in EX.
- `mem_ack` in 1: one-cycle pulse, refill complete.
- `mem_req` out 1: refill request.
- `mem_sel` out 1: refill target; 0 = instruction cache, 1 = data cache.
- `pc_we` out 1: PC load enable.
- `ifid_we` out 1: IF/ID load enable.
- `ifid_flush` out 1: IF/ID clear.
- `idex_we` out 1: ID/EX load enable.
- `idex_bubble` out 1: load all-zero control into ID/EX.
- `exmem_we` out 1: EX/MEM and MEM/WB load enable.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_we` = 0.
- `state` out 2: current FSM state.

## Operation
- FSM states: RUN = 0, IMISS = 1, DMISS = 2.
- `mem_req` = (state != RUN). `mem_sel` = (state == DMISS). Both are Moore outputs.
- Definitions:
  - dmiss = `dm_access` & ~`dm_hit`.
  - imiss = ~`if_hit`.
  - loaduse = `ex_mem_read` & (`ex_rt` != 0) & ((`ex_rt` == `id_rs`) | (`id_uses_rt` & (`ex_rt` == `id_rt`))).
- Transitions:
  - RUN → DMISS on dmiss.
  - RUN → IMISS on imiss & ~dmiss.
  - IMISS on `mem_ack` → DMISS if dmiss, else → RUN.
  - DMISS on `mem_ack` → RUN.
  - `mem_ack` outside IMISS/DMISS is ignored.
- Combinational enables, highest priority first:
  1. dmiss or state == DMISS: every `*_we` = 0; no flush, no bubble. The pipeline is fully frozen.
  2. `ex_branch_taken`: `pc_we` = 1 (loads target), `ifid_flush` = 1, `idex_bubble` = 1. This holds in RUN and in IMISS.
  3. imiss or state == IMISS: `pc_we` = `ifid_we` = 0, `idex_bubble` = 1. Back end runs (`idex_we` = `exmem_we` = 1).
  4. loaduse: `pc_we` = `ifid_we` = 0, `idex_bubble` = 1.
  5. Otherwise all `*_we` = 1; flush and bubble = 0.
- A branch during IMISS does not cancel the refill. `mem_req` stays high until `mem_ack`, and the wrong-path line is filled harmlessly.
- `stall_cycles` increments on each clock with `pc_we` = 0 and holds at all-ones.

## Timing
- Reset (`rst_n` low, asynchronous): state = RUN, `mem_req` = 0, `stall_cycles` = 0.
- While `rst_n` is low, all `*_we`, `ifid_flush` and `idex_bubble` are forced to 0.
- Stall outputs react in the same cycle as the miss or hazard input. `mem_req` rises on the next clock edge.
- On a refill, `mem_ack` is sampled at cycle N; the state is RUN at N+1; the retried access must then hit.
- Load-use costs exactly one bubble. In the following cycle `ex_mem_read` = 0, so the hazard clears.
- Reset asserted mid-refill returns the FSM to RUN and drops `mem_req` immediately. The memory side must tolerate an abandoned request.

## Structure
- Shared package `mips_pkg`:
  - state enum: RUN, IMISS, DMISS.
  - `REG_ZERO` = 5'd0.
  - `REG_ADDR_W`.
- Sub-module `hazard_detect` (combinational): computes loaduse from `id_rs`, `id_rt`, `id_uses_rt`, `ex_mem_read` and `ex_rt`.
- The FSM, priority mux and counter live in `pipe_hazard_ctrl`.

## Test plan
- Load-use: `ex_mem_read` = 1, `ex_rt` = 5, `id_rs` = 5, all hits → exactly one cycle with `pc_we` = 0, `idex_bubble` = 1; `stall_cycles` = 1.
- `ex_rt` = 0 with `id_rs` = 0 → no stall.
- I-miss: `if_hit` = 0, `mem_ack` pulsed 3 cycles after `mem_req` rises:
  - `mem_sel` = 0.
  - `pc_we` = 0 for 5 cycles, with `exmem_we` = 1 throughout.
  - Back to RUN.
- D-miss during IMISS: dmiss raised in IMISS → all enables 0 immediately. On I-ack the state goes to DMISS with `mem_sel` = 1; on the second ack → RUN.
- Branch in IMISS: `ex_branch_taken` = 1 for one cycle in IMISS → `pc_we` = 1, `ifid_flush` = 1 that cycle; `mem_req` stays 1 until ack.
- Reset mid-DMISS: `rst_n` low for 2 cycles → state = 0, `mem_req` = 0 and `stall_cycles` = 0 asynchronously.
- Counter saturation: with `CNT_W` = 4, hold a miss for 20 cycles → `stall_cycles` = 15 and holds.
